sparc_ctrl_pipe: RTL and testbench

- Parametrised successor to the single-stage SPARC instruction decoder.
- Fully decodes the ID-stage instruction, including the load/store, RAM and register-file signals the single-stage version left unset.
- Carries every control word through registered ID/EX, EX/MEM and MEM/WB stages.
- Supports stall (bubble insertion) and flush (squash), and feeds the EX ALU, data RAM and register-file write port.

---
 rtl/sparc_ctrl_pipe_if.sv | 37 +++
 rtl/sparc_ctrl_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_sparc_ctrl_pipe.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_ctrl_pipe_if.sv
// ID-stage instruction/hazard bus and the staged control outputs of sparc_ctrl_pipe.
// master = hazard/fetch side driving the instruction; slave = the control pipe.
interface sparc_ctrl_pipe_if #(
    parameter int ALU_OP_W = 4
);
    logic [31:0]         instr;
    logic                stall;
    logic                flush;
    logic                id_b_instr;
    logic                id_call_instr;
    logic                id_jmpl_instr;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_i13;
    logic                ex_alter_cc;
    logic                mem_ram_en;
    logic                mem_ram_rw;
    logic                mem_ram_se;
    logic [1:0]          mem_ram_size;
    logic                wb_rf_en;
    logic [1:0]          wb_pw_sel;

    modport master (
        output instr, stall, flush,
        input  id_b_instr, id_call_instr, id_jmpl_instr,
        input  ex_alu_op, ex_i13, ex_alter_cc,
        input  mem_ram_en, mem_ram_rw, mem_ram_se, mem_ram_size,
        input  wb_rf_en, wb_pw_sel
    );

    modport slave (
        input  instr, stall, flush,
        output id_b_instr, id_call_instr, id_jmpl_instr,
        output ex_alu_op, ex_i13, ex_alter_cc,
        output mem_ram_en, mem_ram_rw, mem_ram_se, mem_ram_size,
        output wb_rf_en, wb_pw_sel
    );
endinterface

// File: rtl/sparc_ctrl_pipe.sv
// SPARC ID-stage decoder feeding registered EX/MEM/WB control stages with stall/flush bubbles.
// Optional saturating bubble counter enabled by macro SPARC_CTRL_BUBBLE_CNT_EN.
module sparc_ctrl_pipe #(
    parameter int                  ALU_OP_W   = 4,
    parameter logic [ALU_OP_W-1:0] NOP_ALU_OP = ALU_OP_W'(4'b1101),
    parameter int                  PIPE_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    sparc_ctrl_pipe_if.slave bus
`ifdef SPARC_CTRL_BUBBLE_CNT_EN
    ,
    output logic [15:0]      bubble_cnt
`endif
);

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                i13;
        logic                alter_cc;
        logic                ram_en;
        logic                ram_rw;
        logic                ram_se;
        logic [1:0]          ram_size;
        logic                rf_en;
        logic [1:0]          pw_sel;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        alu_op:   NOP_ALU_OP,
        i13:      1'b0,
        alter_cc: 1'b0,
        ram_en:   1'b0,
        ram_rw:   1'b0,
        ram_se:   1'b0,
        ram_size: 2'b00,
        rf_en:    1'b0,
        pw_sel:   2'b01
    };

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       alu_hit;
    logic [3:0] alu_code;
    ctrl_t      dec;
    ctrl_t      ex_d, ex_q;
    ctrl_t      mem_d, mem_s;
    ctrl_t      wb_d, wb_s;

    assign op  = bus.instr[31:30];
    assign op2 = bus.instr[24:22];
    assign op3 = bus.instr[24:19];

    assign bus.id_b_instr    = (op == 2'b00) && (op2 == 3'b010);
    assign bus.id_call_instr = (op == 2'b01);
    assign bus.id_jmpl_instr = (op == 2'b10) && (op3 == 6'b111000);

    // Arithmetic/logic group lives in op3[5]=0 (op3[4] is the cc bit); shifts in 10xxxx.
    always_comb begin
        alu_hit  = 1'b1;
        alu_code = 4'b0000;
        if (!op3[5]) begin
            case (op3[3:0])
                4'b0000: alu_code = 4'b0000;
                4'b0001: alu_code = 4'b0100;
                4'b0010: alu_code = 4'b0101;
                4'b0011: alu_code = 4'b0110;
                4'b0100: alu_code = 4'b0010;
                4'b0101: alu_code = 4'b1000;
                4'b0110: alu_code = 4'b1001;
                4'b0111: alu_code = 4'b0111;
                4'b1000: alu_code = 4'b0001;
                4'b1100: alu_code = 4'b0011;
                default: alu_hit  = 1'b0;
            endcase
        end else if (!op3[4]) begin
            case (op3[3:0])
                4'b0101: alu_code = 4'b1010;
                4'b0110: alu_code = 4'b1011;
                4'b0111: alu_code = 4'b1100;
                default: alu_hit  = 1'b0;
            endcase
        end else begin
            alu_hit = 1'b0;
        end
    end

    // Words the decoder does not recognise (incl. Bicc) leave the bubble defaults in place.
    always_comb begin
        dec = BUBBLE;
        case (op)
            2'b00: begin
                if (op2 == 3'b100) dec.rf_en = 1'b1;
            end
            2'b01: begin
                dec.rf_en  = 1'b1;
                dec.pw_sel = 2'b00;
            end
            2'b10: begin
                if (op3 == 6'b111000) begin
                    dec.alu_op = '0;
                    dec.i13    = bus.instr[13];
                    dec.rf_en  = 1'b1;
                    dec.pw_sel = 2'b00;
                end else if (alu_hit) begin
                    dec.alu_op   = ALU_OP_W'(alu_code);
                    dec.i13      = bus.instr[13];
                    dec.alter_cc = op3[4];
                    dec.rf_en    = 1'b1;
                end
            end
            default: begin
                // Memory ops: op3[2] separates stores (0001xx) from loads.
                dec.alu_op = '0;
                dec.i13    = bus.instr[13];
                dec.ram_en = 1'b1;
                dec.ram_rw = op3[2];
                dec.rf_en  = ~op3[2];
                dec.pw_sel = op3[2] ? 2'b01 : 2'b11;
                case (op3)
                    6'b000000, 6'b000100: dec.ram_size = 2'b10;
                    6'b000001, 6'b000101: dec.ram_size = 2'b00;
                    6'b000010, 6'b000110: dec.ram_size = 2'b01;
                    6'b000011, 6'b000111: dec.ram_size = 2'b11;
                    6'b001001: begin
                        dec.ram_size = 2'b00;
                        dec.ram_se   = 1'b1;
                    end
                    6'b001010: begin
                        dec.ram_size = 2'b01;
                        dec.ram_se   = 1'b1;
                    end
                    default: dec = BUBBLE;
                endcase
            end
        endcase
    end

    always_comb begin
        ex_d  = (bus.stall | bus.flush) ? BUBBLE : dec;
        mem_d = ex_q;
        wb_d  = mem_s;
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= BUBBLE;
        else       ex_q <= ex_d;
    end

    generate
        if (PIPE_DEPTH >= 2) begin : g_mem_reg
            ctrl_t mem_q;
            always_ff @(posedge clk) begin
                if (reset) mem_q <= BUBBLE;
                else       mem_q <= mem_d;
            end
            assign mem_s = mem_q;
        end else begin : g_mem_wire
            assign mem_s = mem_d;
        end

        if (PIPE_DEPTH >= 3) begin : g_wb_reg
            ctrl_t wb_q;
            always_ff @(posedge clk) begin
                if (reset) wb_q <= BUBBLE;
                else       wb_q <= wb_d;
            end
            assign wb_s = wb_q;
        end else begin : g_wb_wire
            assign wb_s = wb_d;
        end
    endgenerate

    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_i13       = ex_q.i13;
    assign bus.ex_alter_cc  = ex_q.alter_cc;
    assign bus.mem_ram_en   = mem_s.ram_en;
    assign bus.mem_ram_rw   = mem_s.ram_rw;
    assign bus.mem_ram_se   = mem_s.ram_se;
    assign bus.mem_ram_size = mem_s.ram_size;
    assign bus.wb_rf_en     = wb_s.rf_en;
    assign bus.wb_pw_sel    = wb_s.pw_sel;

    logic unused_bits;
    assign unused_bits = ^{bus.instr[29:25], bus.instr[18:14], bus.instr[12:0],
                           wb_s.alu_op, wb_s.i13, wb_s.alter_cc, wb_s.ram_en,
                           wb_s.ram_rw, wb_s.ram_se, wb_s.ram_size};

`ifdef SPARC_CTRL_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((bus.stall | bus.flush) && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) bubble_cnt_q <= 16'd0;
        else       bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_sparc_ctrl_pipe.sv
// Directed plus randomized checks of sparc_ctrl_pipe against a mnemonic-level reference model.
module tb_sparc_ctrl_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sparc_ctrl_pipe_if #(.ALU_OP_W(4)) bus ();

`ifdef SPARC_CTRL_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    sparc_ctrl_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SPARC_CTRL_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    // Expected word layout: alu[13:10] i13[9] cc[8] en[7] rw[6] se[5] size[4:3] rf[2] pw[1:0]
    localparam logic [13:0] BUB = {4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    localparam logic [31:0] ADDCC = 32'h8080_4002;
    localparam logic [31:0] ADD   = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0100_0000;
    localparam logic [31:0] LDSB  = 32'hC048_0000;
    localparam logic [31:0] STD   = 32'hC038_0000;
    localparam logic [31:0] LD    = 32'hC000_0000;
    localparam logic [31:0] CALL  = 32'h4000_0000;
    localparam logic [31:0] BICC  = 32'h1080_0000;

    int tests = 0;
    int fails = 0;

    string alu_nm[int];
    int    alu_cd[string];
    string ls_nm[int];
    int    ls_sz[string];
    int    alu_keys[$];
    int    ls_keys[$];

    logic [13:0] pipe[$];
    logic [15:0] cnt_model;

    task automatic add_alu(input string n, input int o3, input int code, input bit has_cc);
        alu_nm[o3] = n;
        alu_cd[n]  = code;
        alu_keys.push_back(o3);
        if (has_cc) begin
            alu_nm[o3 + 16] = {n, "cc"};
            alu_cd[{n, "cc"}] = code;
            alu_keys.push_back(o3 + 16);
        end
    endtask

    task automatic add_ls(input string n, input int o3, input int sz);
        ls_nm[o3] = n;
        ls_sz[n]  = sz;
        ls_keys.push_back(o3);
    endtask

    function automatic string mnem(input logic [31:0] w);
        int o3;
        o3 = int'(w[24:19]);
        case (w[31:30])
            2'b00: begin
                if (w[24:22] == 3'b010) return "bicc";
                if (w[24:22] == 3'b100) return "sethi";
                return "?";
            end
            2'b01: return "call";
            2'b10: begin
                if (o3 == 56) return "jmpl";
                if (alu_nm.exists(o3)) return alu_nm[o3];
                return "?";
            end
            default: begin
                if (ls_nm.exists(o3)) return ls_nm[o3];
                return "?";
            end
        endcase
    endfunction

    function automatic logic [13:0] mk(input logic [3:0] a, input logic i, input logic c,
                                       input logic e, input logic r, input logic s,
                                       input logic [1:0] z, input logic f, input logic [1:0] p);
        return {a, i, c, e, r, s, z, f, p};
    endfunction

    function automatic logic [13:0] ref_word(input logic [31:0] w);
        string m;
        logic  i;
        logic  cc;
        m = mnem(w);
        i = w[13];
        if (m == "call")  return mk(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00);
        if (m == "sethi") return mk(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01);
        if (m == "jmpl")  return mk(4'b0000, i, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00);
        if (alu_cd.exists(m)) begin
            cc = (m.len() > 2) && (m.substr(m.len() - 2, m.len() - 1) == "cc");
            return mk(4'(alu_cd[m]), i, cc, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01);
        end
        if (ls_sz.exists(m)) begin
            if (m.substr(0, 1) == "st")
                return mk(4'b0000, i, 1'b0, 1'b1, 1'b1, 1'b0, 2'(ls_sz[m]), 1'b0, 2'b01);
            return mk(4'b0000, i, 1'b0, 1'b1, 1'b0, (m == "ldsb") || (m == "ldsh"),
                      2'(ls_sz[m]), 1'b1, 2'b11);
        end
        return BUB;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: present inputs, check decode flags, clock, then check every stage.
    task automatic drive(input logic [31:0] i, input logic s, input logic f, input logic r);
        string m;
        bus.instr = i;
        bus.stall = s;
        bus.flush = f;
        reset     = r;
        #1;
        m = mnem(i);
        chk("id_b",    32'(bus.id_b_instr),    32'(m == "bicc"));
        chk("id_call", 32'(bus.id_call_instr), 32'(m == "call"));
        chk("id_jmpl", 32'(bus.id_jmpl_instr), 32'(m == "jmpl"));
        @(posedge clk);
        if (r) begin
            pipe      = '{BUB, BUB, BUB};
            cnt_model = 16'd0;
        end else begin
            pipe.push_front((s | f) ? BUB : ref_word(i));
            void'(pipe.pop_back());
            if ((s | f) && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        end
        #1;
        chk("ex_word",  32'({bus.ex_alu_op, bus.ex_i13, bus.ex_alter_cc}), 32'(pipe[0][13:8]));
        chk("mem_word", 32'({bus.mem_ram_en, bus.mem_ram_rw, bus.mem_ram_se, bus.mem_ram_size}),
            32'(pipe[1][7:3]));
        chk("wb_word",  32'({bus.wb_rf_en, bus.wb_pw_sel}), 32'(pipe[2][2:0]));
`ifdef SPARC_CTRL_BUBBLE_CNT_EN
        chk("bubble_cnt", 32'(bubble_cnt), 32'(cnt_model));
`endif
    endtask

    initial begin
        logic [15:0] cnt_before;
        add_alu("add",  0,  0, 1'b1);
        add_alu("and",  1,  4, 1'b1);
        add_alu("or",   2,  5, 1'b1);
        add_alu("xor",  3,  6, 1'b1);
        add_alu("sub",  4,  2, 1'b1);
        add_alu("andn", 5,  8, 1'b1);
        add_alu("orn",  6,  9, 1'b1);
        add_alu("xnor", 7,  7, 1'b1);
        add_alu("addx", 8,  1, 1'b1);
        add_alu("subx", 12, 3, 1'b1);
        add_alu("sll",  37, 10, 1'b0);
        add_alu("srl",  38, 11, 1'b0);
        add_alu("sra",  39, 12, 1'b0);
        add_ls("ld", 0, 2);  add_ls("ldub", 1, 0); add_ls("lduh", 2, 1);  add_ls("ldd", 3, 3);
        add_ls("ldsb", 9, 0); add_ls("ldsh", 10, 1);
        add_ls("st", 4, 2);  add_ls("stb", 5, 0);  add_ls("sth", 6, 1);   add_ls("std", 7, 3);
        pipe      = '{BUB, BUB, BUB};
        cnt_model = 16'd0;

        // Reset state
        drive(NOP, 1'b0, 1'b0, 1'b1);
        drive(NOP, 1'b0, 1'b0, 1'b1);
        chk("rst_ex_alu", 32'(bus.ex_alu_op), 32'h0000_000D);
        chk("rst_wb_pw",  32'(bus.wb_pw_sel), 32'd1);

        // addcc then NOPs
        drive(ADDCC, 1'b0, 1'b0, 1'b0);
        chk("addcc_ex_alu", 32'(bus.ex_alu_op), 32'd0);
        chk("addcc_ex_cc",  32'(bus.ex_alter_cc), 32'd1);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("addcc_wb_rf", 32'(bus.wb_rf_en), 32'd1);
        chk("addcc_wb_pw", 32'(bus.wb_pw_sel), 32'd1);
        drive(NOP, 1'b0, 1'b0, 1'b0);

        // ldsb
        drive(LDSB, 1'b0, 1'b0, 1'b0);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("ldsb_mem", 32'({bus.mem_ram_en, bus.mem_ram_rw, bus.mem_ram_se, bus.mem_ram_size}),
            32'b1_0_1_00);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("ldsb_wb", 32'({bus.wb_rf_en, bus.wb_pw_sel}), 32'b1_11);

        // std
        drive(STD, 1'b0, 1'b0, 1'b0);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("std_mem", 32'({bus.mem_ram_en, bus.mem_ram_rw, bus.mem_ram_size}), 32'b1_1_11);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("std_wb_rf", 32'(bus.wb_rf_en), 32'd0);

        // three adds, second stalled
        cnt_before = cnt_model;
        drive(ADD, 1'b0, 1'b0, 1'b0);
        chk("stall_ex0", 32'(bus.ex_alu_op), 32'd0);
        drive(ADD, 1'b1, 1'b0, 1'b0);
        chk("stall_ex1", 32'(bus.ex_alu_op), 32'hD);
        drive(ADD, 1'b0, 1'b0, 1'b0);
        chk("stall_ex2", 32'(bus.ex_alu_op), 32'd0);
        chk("stall_wb0", 32'(bus.wb_rf_en), 32'd1);
        drive(ADD, 1'b0, 1'b0, 1'b0);
        chk("stall_wb1", 32'(bus.wb_rf_en), 32'd0);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("stall_wb2", 32'(bus.wb_rf_en), 32'd1);
`ifdef SPARC_CTRL_BUBBLE_CNT_EN
        chk("stall_cnt", 32'(bubble_cnt - cnt_before), 32'd1);
`endif

        // flush and stall together on a call
        cnt_before = cnt_model;
        drive(CALL, 1'b1, 1'b1, 1'b0);
        chk("flush_ex_alu", 32'(bus.ex_alu_op), 32'hD);
`ifdef SPARC_CTRL_BUBBLE_CNT_EN
        chk("flush_cnt", 32'(bubble_cnt - cnt_before), 32'd1);
`endif
        drive(BICC, 1'b0, 1'b0, 1'b0);

        // reset while a load is in MEM
        drive(LD, 1'b0, 1'b0, 1'b0);
        drive(NOP, 1'b0, 1'b0, 1'b0);
        chk("ld_in_mem", 32'(bus.mem_ram_en), 32'd1);
        drive(NOP, 1'b0, 1'b0, 1'b1);
        chk("rst_mem_en", 32'(bus.mem_ram_en), 32'd0);
        chk("rst_wb_rf",  32'(bus.wb_rf_en), 32'd0);
`ifdef SPARC_CTRL_BUBBLE_CNT_EN
        chk("rst_cnt", 32'(bubble_cnt), 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            int          k;
            logic        s, f, r;
            w = $urandom;
            k = $urandom_range(0, 5);
            case (k)
                0: begin
                    w[31:30] = 2'b10;
                    w[24:19] = 6'(alu_keys[$urandom_range(0, alu_keys.size() - 1)]);
                end
                1: begin
                    w[31:30] = 2'b11;
                    w[24:19] = 6'(ls_keys[$urandom_range(0, ls_keys.size() - 1)]);
                end
                2: w[31:30] = 2'b01;
                3: begin
                    w[31:30] = 2'b10;
                    w[24:19] = 6'b111000;
                end
                4: begin
                    w[31:30] = 2'b00;
                    if ($urandom_range(0, 2) != 0) w[24:22] = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b100;
                end
                default: ;
            endcase
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 40) == 0);
            drive(w, s, f, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
